// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: function codes, FSM states, defaults.
// The function codes match the control decoder's R-type encoding.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on magnitudes.
// After WIDTH steps: multiply -> {acc, sreg} = product; divide -> acc = remainder, sreg = quotient.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sreg
);

    logic [WIDTH-1:0] opb;
    mode_t            mode_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sreg_next;

    // Per-iteration step for the latched mode.
    always_comb begin
        acc_next  = acc;
        sreg_next = sreg;
        sum       = {1'b0, acc} + (sreg[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        shifted   = {acc, sreg[WIDTH-1]};
        diff      = shifted - {1'b0, opb};
        if (mode_q == MODE_MUL) begin
            // Multiplier bits leave sreg from the bottom while product bits enter from the top.
            acc_next  = sum[WIDTH:1];
            sreg_next = {sum[0], sreg[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_next  = diff[WIDTH-1:0];
            sreg_next = {sreg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next  = shifted[WIDTH-1:0];
            sreg_next = {sreg[WIDTH-2:0], 1'b0};
        end
    end

    // Datapath registers: load operands on accept, step once per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= {WIDTH{1'b0}};
            sreg   <= {WIDTH{1'b0}};
            opb    <= {WIDTH{1'b0}};
            mode_q <= MODE_MUL;
        end else if (load) begin
            acc    <= {WIDTH{1'b0}};
            sreg   <= a;
            opb    <= b;
            mode_q <= mode;
        end else if (step) begin
            acc    <= acc_next;
            sreg   <= sreg_next;
        end else begin
            acc    <= acc;
            sreg   <= sreg;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; start/busy/done handshake, 33-cycle latency.
// Operands are reduced to magnitudes on accept; signs are reapplied in the FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               neg_main;
    logic               neg_rem;
    mode_t              mode;

    logic               is_mul;
    logic               is_div;
    logic               is_signed;
    logic               accept;
    logic               go_calc;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sreg;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_mul    = (op == FN_MULT) || (op == FN_MULTU);
    assign is_div    = (op == FN_DIV) || (op == FN_DIVU);
    assign is_signed = (op == FN_MULT) || (op == FN_DIV);
    assign accept    = start && (state == ST_IDLE);
    assign go_calc   = accept && (is_mul || (is_div && (rt != {WIDTH{1'b0}})));
    assign mag_a     = (is_signed && rs[WIDTH-1]) ? -rs : rs;
    assign mag_b     = (is_signed && rt[WIDTH-1]) ? -rt : rt;
    assign stall     = busy && ((op == FN_MFHI) || (op == FN_MFLO));

    // Sign correction; -2**31 / -1 falls out as lo=0x80000000, hi=0 with no negation.
    assign prod      = {acc, sreg};
    assign prod_fix  = neg_main ? -prod : prod;
    assign quot_fix  = neg_main ? -sreg : sreg;
    assign rem_fix   = neg_rem ? -acc : acc;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (go_calc),
        .step (state == ST_CALC),
        .mode (is_div ? MODE_DIV : MODE_MUL),
        .a    (mag_a),
        .b    (mag_b),
        .acc  (acc),
        .sreg (sreg)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (go_calc) begin
                    state_next = ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt == {CNT_W{1'b0}}) begin
                    state_next = ST_FIX;
                end else begin
                    state_next = ST_CALC;
                end
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake flags, iteration counter, sign flags and the architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= {CNT_W{1'b0}};
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            mode     <= MODE_MUL;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go_calc) begin
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        cnt      <= CNT_W'(WIDTH - 1);
                        neg_main <= is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        neg_rem  <= is_signed && is_div && rs[WIDTH-1];
                        mode     <= is_div ? MODE_DIV : MODE_MUL;
                    end else if (accept && is_div) begin
                        hi       <= rs;
                        lo       <= {WIDTH{1'b1}};
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                    end else if (accept && (op == FN_MTHI)) begin
                        hi <= rs;
                    end else if (accept && (op == FN_MTLO)) begin
                        lo <= rs;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (mode == MODE_MUL) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;

    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_bad;

    mult_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge; returns 1 time unit after that edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = f;
        rs    = a;
        rt    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; bounded so a dead DUT cannot hang the run.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 6'b000000; rs = 32'h0; rt = 32'h0;
        #3;
        n_vec++; if (hi !== 32'h0)    begin n_bad++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        n_vec++; if (lo !== 32'h0)    begin n_bad++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        n_vec++; if ({busy, done, div_zero, stall} !== 4'b0000)
            begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, div_zero, stall}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_moves();
        issue(OP_MTLO, 32'h0000_1234, 32'h0);
        n_vec++; if (lo !== 32'h0000_1234) begin n_bad++; $display("FAIL mtlo_lo: got %h want 00001234", lo); end
        n_vec++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL mtlo_flags: got %b want 00", {busy, done}); end
        issue(OP_MTHI, 32'h5555_AAAA, 32'h0);
        n_vec++; if (hi !== 32'h5555_AAAA) begin n_bad++; $display("FAIL mthi_hi: got %h want 5555aaaa", hi); end
        n_vec++; if (lo !== 32'h0000_1234) begin n_bad++; $display("FAIL mthi_lo_kept: got %h want 00001234", lo); end
    endtask

    task automatic test_mult();
        int c;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy: got %b want 1", busy); end
        n_vec++; if (hi !== 32'h5555_AAAA) begin n_bad++; $display("FAIL mult_hi_held: got %h want 5555aaaa", hi); end
        wait_done(c);
        n_vec++; if (c != 33) begin n_bad++; $display("FAIL mult_latency: got %0d want 33", c); end
        n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mult_neg: got %h%h want ffffffffffffffeb", hi, lo); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_clr: got %b want 0", busy); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL mult_done_pulse: got %b want 0", done); end
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(c);
        n_vec++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL multu_max: got %h%h want fffffffe00000001", hi, lo); end
    endtask

    task automatic test_div();
        int c;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(c);
        n_vec++; if (c != 33) begin n_bad++; $display("FAIL div_latency: got %0d want 33", c); end
        n_vec++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL div_neg_dividend: got %h %h want ffffffff fffffffd", hi, lo); end
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(c);
        n_vec++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL divu_100_7: got %h %h want 00000002 0000000e", hi, lo); end
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(c);
        n_vec++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_bad++; $display("FAIL div_neg_divisor: got %h %h want 00000001 fffffffd", hi, lo); end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(c);
        n_vec++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_bad++; $display("FAIL div_overflow: got %h %h want 00000000 80000000", hi, lo); end
        n_vec++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL div_overflow_flag: got %b want 0", div_zero); end
    endtask

    task automatic test_div_zero();
        int c;
        issue(OP_DIV, 32'd5, 32'd0);
        n_vec++; if ({done, div_zero, busy} !== 3'b110) begin n_bad++; $display("FAIL dz_flags: got %b want 110", {done, div_zero, busy}); end
        n_vec++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin n_bad++; $display("FAIL dz_result: got %h %h want 00000005 ffffffff", hi, lo); end
        @(posedge clk); #1;
        n_vec++; if ({done, div_zero} !== 2'b01) begin n_bad++; $display("FAIL dz_sticky: got %b want 01", {done, div_zero}); end
        issue(OP_MULT, 32'd2, 32'd3);
        n_vec++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL dz_clear: got %b want 0", div_zero); end
        wait_done(c);
        n_vec++; if ({hi, lo} !== 64'd6) begin n_bad++; $display("FAIL dz_next_mult: got %h %h want 00000000 00000006", hi, lo); end
    endtask

    task automatic test_mid_op();
        int c;
        issue(OP_MTHI, 32'h0000_5555, 32'h0);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        issue(OP_MTHI, 32'h0000_DEAD, 32'h0);
        n_vec++; if (hi !== 32'h0000_5555) begin n_bad++; $display("FAIL midop_mthi_ignored: got %h want 00005555", hi); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midop_busy: got %b want 1", busy); end
        op = OP_MFLO;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL midop_stall: got %b want 1", stall); end
        op = OP_MTHI;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midop_nostall_mthi: got %b want 0", stall); end
        op = OP_MFHI;
        wait_done(c);
        n_vec++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL midop_result: got %h %h want 00000002 0000000e", hi, lo); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midop_stall_release: got %b want 0", stall); end
    endtask

    task automatic test_reset_mid();
        int c;
        issue(OP_MULT, 32'h10, 32'h10);
        repeat (14) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL rstmid_hilo: got %h %h want 0 0", hi, lo); end
        n_vec++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL rstmid_flags: got %b want 00", {busy, done}); end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got %b want 0", busy); end
        issue(OP_MULT, 32'h10, 32'h10);
        wait_done(c);
        n_vec++; if (c != 33 || lo !== 32'h100) begin n_bad++; $display("FAIL rstmid_recover: got %0d cycles lo %h want 33 cycles lo 00000100", c, lo); end
    endtask

    task automatic test_back_to_back();
        int c;
        issue(OP_MULT, 32'd3, 32'd4);
        wait_done(c);
        n_vec++; if (lo !== 32'd12) begin n_bad++; $display("FAIL b2b_first: got %h want 0000000c", lo); end
        issue(OP_MULT, 32'd5, 32'd6);
        n_vec++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL b2b_accept: got %b want 10", {busy, done}); end
        wait_done(c);
        n_vec++; if (c != 33) begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", c); end
        n_vec++; if ({hi, lo} !== 64'd30) begin n_bad++; $display("FAIL b2b_second: got %h %h want 00000000 0000001e", hi, lo); end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_moves();
        test_mult();
        test_div();
        test_div_zero();
        test_mid_op();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
